// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch front end:
// bus widths, stall encoding, branch/IF->ID bus layouts and hold-buffer states.
package if_fetch_ctrl_pkg;

    localparam int STALL_W     = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFBF_FFFC;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    // {br_e, br_addr} from ID
    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    // {ce, pc} towards ID
    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    typedef enum logic {
        HB_PASS = 1'b0,
        HB_HOLD = 1'b1
    } hold_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Signal bundle between the fetch controller (master) and the pipeline/SRAM side (slave).
// fetch_adel exists only when IF_ALIGN_CHK_EN is defined.
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic [STALL_W-1:0] stall;
    br_bus_t            br_bus;
    logic [31:0]        inst_sram_rdata;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [31:0]        inst_sram_addr;
    logic [31:0]        inst_sram_wdata;
    if_to_id_t          if_to_id_bus;
    logic [31:0]        if_inst;
`ifdef IF_ALIGN_CHK_EN
    logic               fetch_adel;

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output if_to_id_bus, if_inst, fetch_adel
    );
    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  if_to_id_bus, if_inst, fetch_adel
    );
`else
    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output if_to_id_bus, if_inst
    );
    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  if_to_id_bus, if_inst
    );
`endif

endinterface

// File: rtl/if_fetch_ctrl_hold_buf.sv
// Instruction hold buffer: latches the SRAM word when IF/ID and the stage behind it
// are both stopped, so ID keeps seeing the same instruction through the stall.
module inst_hold_buf
    import if_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stop,
    input  logic        id_next_stop,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    hold_state_e state_q, state_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        both_stop;

    assign both_stop = (id_stop == STOP) && (id_next_stop == STOP);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HB_PASS;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        hold_inst_d = hold_inst_q;
        case (state_q)
            HB_PASS: begin
                if (both_stop) begin
                    state_d     = HB_HOLD;
                    hold_inst_d = rdata;
                end
            end
            HB_HOLD: begin
                // Releasing either stop (including the bubble case) returns to pass-through.
                if (!both_stop) state_d = HB_PASS;
            end
            default: state_d = HB_PASS;
        endcase
    end

    always_comb begin
        inst = (state_q == HB_HOLD) ? hold_inst_q : rdata;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF stage controller: PC, fetch enable, pending-redirect register and IF->ID bus.
// Optional IF_ALIGN_CHK_EN adds fetch_adel and suppresses misaligned fetches.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_ctrl_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] next_pc;
    logic        adel;
    logic [31:0] buf_inst;
    logic [2:0]  unused_stall;
    br_bus_t     br;

    assign br           = bus.br_bus;
    assign unused_stall = bus.stall[STALL_W-1:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        if (br.br_e)       next_pc = br.br_addr;
        else if (pend_v_q) next_pc = pend_addr_q;
        else               next_pc = pc_q + PC_STEP;
    end

    always_comb begin
        ce_d        = 1'b1;
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if (bus.stall[0] == NOSTOP) begin
            pc_d     = next_pc;
            pend_v_d = 1'b0;
        end else if (br.br_e) begin
            // Remember the latest branch target until the PC is allowed to move.
            pend_v_d    = 1'b1;
            pend_addr_d = br.br_addr;
        end
    end

`ifdef IF_ALIGN_CHK_EN
    assign adel           = ce_q && (pc_q[1:0] != 2'b00);
    assign bus.fetch_adel = adel;
`else
    assign adel = 1'b0;
`endif

    inst_hold_buf u_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .id_stop      (bus.stall[1]),
        .id_next_stop (bus.stall[2]),
        .rdata        (bus.inst_sram_rdata),
        .inst         (buf_inst)
    );

    assign bus.inst_sram_en    = ce_q && !adel;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = 32'b0;
    assign bus.if_to_id_bus    = '{ce: ce_q && !adel, pc: pc_q};
    assign bus.if_inst         = adel ? 32'b0 : buf_inst;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the fetch front end.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_redirect[$];
    logic        m_held;
    logic [31:0] m_word;
    logic        m_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic [31:0] rd);
        logic adel;
        adel = 1'b0;
`ifdef IF_ALIGN_CHK_EN
        adel = m_ce && (m_pc[1:0] != 2'b00);
        check("fetch_adel", 64'(bus.fetch_adel), 64'(adel));
`endif
        check("sram_en",    64'(bus.inst_sram_en),    64'(m_ce && !adel));
        check("sram_addr",  64'(bus.inst_sram_addr),  64'(m_pc));
        check("sram_wen",   64'(bus.inst_sram_wen),   64'(0));
        check("sram_wdata", 64'(bus.inst_sram_wdata), 64'(0));
        check("if_to_id",   64'(bus.if_to_id_bus),    64'({m_ce && !adel, m_pc}));
        check("if_inst",    64'(bus.if_inst),
              64'(adel ? 32'h0 : (m_held ? m_word : rd)));
    endtask

    task automatic model_update(input logic r, input logic [5:0] s, input logic be,
                                input logic [31:0] ba, input logic [31:0] rd);
        logic [31:0] target;
        if (r) begin
            m_pc = RESET_PC_DEF;
            m_ce = 1'b0;
            m_redirect.delete();
            m_held = 1'b0;
            m_word = 32'h0;
            m_valid = 1'b1;
            return;
        end
        m_ce = 1'b1;
        if (be)                       target = ba;
        else if (m_redirect.size()>0) target = m_redirect[0];
        else                          target = m_pc + 32'd4;
        if (!s[0]) begin
            m_pc = target;
            m_redirect.delete();
        end else if (be) begin
            m_redirect.delete();
            m_redirect.push_back(ba);
        end
        if (!m_held && s[1] && s[2]) begin
            m_held = 1'b1;
            m_word = rd;
        end else if (m_held && !(s[1] && s[2])) begin
            m_held = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, check, let the rising edge happen, update the model.
    task automatic step(input logic r, input logic [5:0] s, input logic be,
                        input logic [31:0] ba, input logic [31:0] rd);
        rst                 = r;
        bus.stall           = s;
        bus.br_bus          = '{br_e: be, br_addr: ba};
        bus.inst_sram_rdata = rd;
        #1;
        if (m_valid) check_outputs(rd);
        @(posedge clk);
        model_update(r, s, be, ba, rd);
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] rd);
        step(1'b0, 6'b0, 1'b0, 32'h0, rd);
    endtask

    initial begin
        logic        r, be;
        logic [5:0]  s;
        logic [31:0] ba;

        rst = 1'b1;
        bus.stall = '0;
        bus.br_bus = '0;
        bus.inst_sram_rdata = '0;
        @(negedge clk);

        // 1: reset for 3 cycles, then sequential fetch
        repeat (3) step(1'b1, 6'b0, 1'b0, 32'h0, 32'h1111_0000);
        check("rst_en", 64'(bus.inst_sram_en), 64'(0));
        check("rst_bus", 64'(bus.if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        check("rst_inst", 64'(bus.if_inst), 64'(32'h1111_0000));
        idle(32'h0);
        check("t1_addr0", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0000));
        check("t1_en", 64'(bus.inst_sram_en), 64'(1));
        idle(32'h0);
        check("t1_addr1", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0004));
        idle(32'h0);
        check("t1_addr2", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0008));

        // 2: branch taken at pc BFC0_0010
        idle(32'h0);
        idle(32'h0);
        check("t2_pc", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0010));
        step(1'b0, 6'b0, 1'b1, 32'hBFC0_0100, 32'h0);
        check("t2_target", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0100));
        idle(32'h0);
        check("t2_seq", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0104));

        // 3: branch arriving while the PC is stalled becomes pending
        step(1'b0, 6'b000111, 1'b0, 32'h0, 32'h0);
        step(1'b0, 6'b000111, 1'b1, 32'hBFC0_0200, 32'h0);
        step(1'b0, 6'b000111, 1'b0, 32'h0, 32'h0);
        check("t3_hold", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0104));
        idle(32'h0);
        check("t3_pend", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0200));

        // 4: hold buffer keeps the captured word through an IF/ID stall
        step(1'b0, 6'b000110, 1'b0, 32'h0, 32'h2408_0001);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 6'b000110, 1'b0, 32'h0, 32'hFFFF_FFFF);
            check("t4_held", 64'(bus.if_inst), 64'(32'h2408_0001));
        end
        idle(32'h1234_5678);
        check("t4_release", 64'(bus.if_inst), 64'(32'h1234_5678));

        // 5: reset while a redirect is pending and the buffer is holding
        step(1'b0, 6'b000111, 1'b1, 32'hBFC0_0300, 32'hAAAA_5555);
        step(1'b1, 6'b000111, 1'b0, 32'h0, 32'h0BAD_F00D);
        check("t5_inst", 64'(bus.if_inst), 64'(32'h0BAD_F00D));
        idle(32'h0);
        check("t5_restart", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0000));

        // PC wraps modulo 2^32
        step(1'b0, 6'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        check("wrap_pre", 64'(bus.inst_sram_addr), 64'(32'hFFFF_FFFC));
        idle(32'h0);
        check("wrap_post", 64'(bus.inst_sram_addr), 64'(32'h0000_0000));

`ifdef IF_ALIGN_CHK_EN
        // 6: misaligned target produces a bubble
        step(1'b0, 6'b0, 1'b1, 32'hBFC0_0102, 32'h5555_AAAA);
        check("t6_adel", 64'(bus.fetch_adel), 64'(1));
        check("t6_en", 64'(bus.inst_sram_en), 64'(0));
        check("t6_ce", 64'(bus.if_to_id_bus.ce), 64'(0));
        check("t6_inst", 64'(bus.if_inst), 64'(0));
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = 6'($urandom);
            s[0] = ($urandom_range(0, 3) == 0);
            s[1] = ($urandom_range(0, 2) == 0);
            s[2] = ($urandom_range(0, 2) != 0);
            be = ($urandom_range(0, 5) == 0);
            ba = $urandom;
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            step(r, s, be, ba, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
